mdio_master: RTL

Parametrised Clause-22 MDIO management master: accepts single read or write commands over a valid/ready handshake, serialises the full management frame on MDC/MDIO and returns a response (read data plus turnaround error flag) for every command. It is the successor to the fixed write-only PHY configuration block. It sits between the PHY-init sequencer and the board-level MDIO tri-state pad, which is instantiated outside this block.

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_master_if.sv | 32 +++
 rtl/mdio_clk_gen.sv | 44 ++++
 rtl/mdio_master.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants and state encoding for the Clause-22 MDIO master.
//   ST / OP_*   : frame start and opcode fields
//   ADDR_W      : PHY / register address width
//   DATA_W      : management data width
//   HDR_LEN     : ST + OP + PHYAD + REGAD bit count
//   mdio_state_e: frame sequencer states
package mdio_pkg;

   localparam logic [1:0] ST    = 2'b01;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 16;
   localparam int HDR_LEN = 14;
   localparam int TA_LEN  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_DONE
   } mdio_state_e;

endpackage

// File: rtl/mdio_master_if.sv
// mdio_master_if: command / response bundle between the PHY-init sequencer and
// the MDIO master.
//   master modport : command source (sequencer) side
//   slave  modport : mdio_master side
//   cmd_*          : single read/write command, valid/ready handshake
//   rsp_*          : one-cycle response pulse with read data and TA error flag
//   busy           : frame in progress
interface mdio_master_if;
   import mdio_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_rd;
   logic [ADDR_W-1:0] cmd_phy_addr;
   logic [ADDR_W-1:0] cmd_reg_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output cmd_valid, cmd_rd, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_rd, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

endinterface

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC generator. Each MDC period is CLK_DIV sys_clk cycles low
// followed by CLK_DIV cycles high, starting low when enabled.
//   sys_clk, sys_rst : clock, async active-high reset
//   en               : run enable; while low MDC is parked at 0
//   mdc              : registered management clock
//   rise_stb         : high in the cycle whose closing edge drives mdc 0->1
//   fall_stb         : high in the cycle whose closing edge drives mdc 1->0
module mdio_clk_gen #(
   parameter int CLK_DIV = 10
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic en,
   output logic mdc,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int            CW       = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap     = en && (cnt == CNT_LAST);
   assign rise_stb = wrap && !mdc;
   assign fall_stb = wrap && mdc;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (wrap) begin
         cnt <= '0;
         mdc <= ~mdc;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master. Accepts one read or write
// command, serialises PRE_LEN preamble bits plus the 32-bit frame on MDC/MDIO
// and returns a response for every command.
//   sys_clk, sys_rst : clock, async active-high reset
//   bus (slave)      : cmd_* handshake, rsp_* pulse, busy
//   mdc              : management clock (0 while idle)
//   mdio_o, mdio_oe  : pad output data / output enable
//   mdio_i           : pad input, sampled on MDC rising
module mdio_master
   import mdio_pkg::*;
#(
   parameter int CLK_DIV = 10,
   parameter int PRE_LEN = 32
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   mdio_master_if.slave bus,
   output logic         mdc,
   output logic         mdio_o,
   output logic         mdio_oe,
   input  logic         mdio_i
);

   // Bit counter holds "bits left in this phase minus one".
   localparam logic [5:0] PRE_LAST  = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;
   localparam logic [5:0] HDR_LAST  = 6'(HDR_LEN - 1);
   localparam logic [5:0] TA_LAST   = 6'(TA_LEN - 1);
   localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);

   mdio_state_e       state, state_nx;
   logic              accept;
   logic              rise_stb, fall_stb;
   logic              phase_end;
   logic [5:0]        bit_cnt, cnt_reload;
   logic              rd_q, rd_eff;
   logic [31:0]       frame, sh;
   logic [DATA_W-1:0] rx_sh;
   logic              ta_err;
   logic              ready_d, busy_d, rsp_valid_d, oe_d, o_d;

   assign accept    = bus.cmd_valid && bus.cmd_ready;
   assign phase_end = fall_stb && (bit_cnt == 6'd0);

   // Post-preamble frame. For reads, TA and DATA are filled with ones so the
   // output parks high while the line is released.
   assign frame = bus.cmd_rd
      ? {ST, OP_RD, bus.cmd_phy_addr, bus.cmd_reg_addr, 18'h3FFFF}
      : {ST, OP_WR, bus.cmd_phy_addr, bus.cmd_reg_addr, 2'b10, bus.cmd_wdata};

   mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .en       (bus.busy),
      .mdc      (mdc),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // State register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next state: phases advance only on the MDC falling strobe
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (accept)    state_nx = (PRE_LEN > 0) ? S_PRE : S_HDR;
         S_PRE:  if (phase_end) state_nx = S_HDR;
         S_HDR:  if (phase_end) state_nx = S_TA;
         S_TA:   if (phase_end) state_nx = S_DATA;
         S_DATA: if (phase_end) state_nx = S_DONE;
         S_DONE:                state_nx = S_IDLE;
         default:               state_nx = S_IDLE;
      endcase
   end

   // Outputs: next values of the registered outputs, decoded from state_nx so
   // pad changes line up with bit starts (accept edge or MDC fall).
   always_comb begin
      ready_d     = (state_nx == S_IDLE);
      busy_d      = (state_nx == S_PRE) || (state_nx == S_HDR) ||
                    (state_nx == S_TA)  || (state_nx == S_DATA);
      rsp_valid_d = (state == S_DONE);
      rd_eff      = accept ? bus.cmd_rd : rd_q;
      oe_d        = busy_d && !(rd_eff && ((state_nx == S_TA) || (state_nx == S_DATA)));
      o_d         = mdio_o;
      if (!busy_d)                o_d = 1'b1;
      else if (state_nx == S_PRE) o_d = 1'b1;
      else if (accept)            o_d = frame[31];
      else if (fall_stb)          o_d = (state == S_PRE) ? sh[31] : sh[30];

      case (state_nx)
         S_PRE:   cnt_reload = PRE_LAST;
         S_HDR:   cnt_reload = HDR_LAST;
         S_TA:    cnt_reload = TA_LAST;
         S_DATA:  cnt_reload = DATA_LAST;
         default: cnt_reload = 6'd0;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bus.cmd_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         mdio_o        <= 1'b1;
         mdio_oe       <= 1'b0;
         rd_q          <= 1'b0;
         sh            <= '0;
         rx_sh         <= '0;
         ta_err        <= 1'b0;
         bit_cnt       <= '0;
      end else begin
         bus.cmd_ready <= ready_d;
         bus.busy      <= busy_d;
         bus.rsp_valid <= rsp_valid_d;
         mdio_o        <= o_d;
         mdio_oe       <= oe_d;

         if (accept) begin
            rd_q    <= bus.cmd_rd;
            sh      <= frame;
            bit_cnt <= cnt_reload;
            rx_sh   <= '0;
            ta_err  <= 1'b0;
         end else if (fall_stb) begin
            // Preamble bits are implicit; the frame shifter starts after them
            if (state != S_PRE) sh <= {sh[30:0], 1'b1};
            bit_cnt <= phase_end ? cnt_reload : bit_cnt - 1'b1;
         end

         if (rise_stb && rd_q) begin
            if ((state == S_TA) && (bit_cnt == 6'd0)) ta_err <= mdio_i;
            if (state == S_DATA) rx_sh <= {rx_sh[DATA_W-2:0], mdio_i};
         end

         if (state == S_DONE) begin
            bus.rsp_rdata <= rd_q ? rx_sh : '0;
            bus.rsp_err   <= rd_q && ta_err;
         end
      end
   end

endmodule
